// File: rtl/id_ex_registers.sv
// id_ex_registers: ID/EX pipeline register of the 5-stage CPU.
// Latches decoded operands, immediate, register indices and control for EX,
// detects load-use hazards against the held instruction, inserts a bubble on
// stall and freezes completely while memory is not ready.
// Optional build macro: ID_EX_BUBBLE_COUNT_EN adds the bubble_count output.
module id_ex_registers #(
    parameter int unsigned CTRL_W    = 12,
    parameter int unsigned M2REG_BIT = 1,
    parameter int unsigned WREG_BIT  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_shouldStall,
    input  logic              mem_hold,
    input  logic [31:0]       id_pc_4,
    input  logic [31:0]       id_instruction,
    input  logic [31:0]       id_regData1,
    input  logic [31:0]       id_regData2,
    input  logic [31:0]       id_immediate,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [CTRL_W-1:0] id_ctrl,
    output logic [31:0]       ex_pc_4,
    output logic [31:0]       ex_instruction,
    output logic [31:0]       ex_regData1,
    output logic [31:0]       ex_regData2,
    output logic [31:0]       ex_immediate,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_valid,
    output logic              loadUseStall
`ifdef ID_EX_BUBBLE_COUNT_EN
    ,
    output logic [31:0]       bubble_count
`endif
);

    // Control bit indices must address a real bit of the bundle.
    if (M2REG_BIT >= CTRL_W || WREG_BIT >= CTRL_W) begin : g_param_check
        $error("id_ex_registers: control bit index outside CTRL_W");
    end

    logic bubble;

    // Load-use hazard: EX holds a real load whose destination is a source of ID.
    always_comb begin
        loadUseStall = ex_valid && ex_ctrl[M2REG_BIT] && (ex_rd != 5'd0)
                       && ((ex_rd == id_rs) || (ex_rd == id_rt));
        bubble       = loadUseStall || id_shouldStall;
    end

    // Pipeline register: hold beats bubble, bubble beats normal load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_pc_4        <= '0;
            ex_instruction <= '0;
            ex_regData1    <= '0;
            ex_regData2    <= '0;
            ex_immediate   <= '0;
            ex_rs          <= '0;
            ex_rt          <= '0;
            ex_rd          <= '0;
            ex_ctrl        <= '0;
            ex_valid       <= 1'b0;
        end else if (!mem_hold) begin
            if (bubble) begin
                ex_pc_4        <= '0;
                ex_instruction <= '0;
                ex_regData1    <= '0;
                ex_regData2    <= '0;
                ex_immediate   <= '0;
                ex_rs          <= '0;
                ex_rt          <= '0;
                ex_rd          <= '0;
                ex_ctrl        <= '0;
                ex_valid       <= 1'b0;
            end else begin
                ex_pc_4        <= id_pc_4;
                ex_instruction <= id_instruction;
                ex_regData1    <= id_regData1;
                ex_regData2    <= id_regData2;
                ex_immediate   <= id_immediate;
                ex_rs          <= id_rs;
                ex_rt          <= id_rt;
                ex_rd          <= id_rd;
                ex_ctrl        <= id_ctrl;
                ex_valid       <= 1'b1;
            end
        end
    end

`ifdef ID_EX_BUBBLE_COUNT_EN
    // Count bubbles that actually enter EX; wraps naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_count <= '0;
        end else if (bubble && !mem_hold) begin
            bubble_count <= bubble_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_registers.sv
// tb_id_ex_registers: self-checking bench for id_ex_registers.
module tb_id_ex_registers;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_shouldStall, mem_hold;
    logic [31:0] id_pc_4, id_instruction, id_regData1, id_regData2, id_immediate;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [11:0] id_ctrl;
    logic [31:0] ex_pc_4, ex_instruction, ex_regData1, ex_regData2, ex_immediate;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [11:0] ex_ctrl;
    logic        ex_valid, loadUseStall;
`ifdef ID_EX_BUBBLE_COUNT_EN
    logic [31:0] bubble_count;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        hold, stall;
        logic [31:0] pc4, instr, rd1, rd2, imm;
        logic [4:0]  rs, rt, rd;
        logic [11:0] ctrl;
        logic        exp_lus, exp_valid;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc4, instr, rd1, rd2, imm;
        logic [4:0]  rs, rt, rd;
        logic [11:0] ctrl;
        logic        valid;
    } out_t;

    out_t model;
    out_t sbq[$];
    vec_t vecs[18];

    id_ex_registers #(.CTRL_W(12), .M2REG_BIT(1), .WREG_BIT(0)) dut (
        .clk(clk), .rst(rst), .id_shouldStall(id_shouldStall), .mem_hold(mem_hold),
        .id_pc_4(id_pc_4), .id_instruction(id_instruction), .id_regData1(id_regData1),
        .id_regData2(id_regData2), .id_immediate(id_immediate), .id_rs(id_rs),
        .id_rt(id_rt), .id_rd(id_rd), .id_ctrl(id_ctrl), .ex_pc_4(ex_pc_4),
        .ex_instruction(ex_instruction), .ex_regData1(ex_regData1),
        .ex_regData2(ex_regData2), .ex_immediate(ex_immediate), .ex_rs(ex_rs),
        .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .ex_valid(ex_valid),
        .loadUseStall(loadUseStall)
`ifdef ID_EX_BUBBLE_COUNT_EN
        , .bubble_count(bubble_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic hold, input logic stall, input logic [31:0] pc4,
                                input logic [31:0] instr, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] rd,
                                input logic [11:0] ctrl, input logic exp_lus,
                                input logic exp_valid);
        vec_t v;
        v.hold = hold; v.stall = stall; v.pc4 = pc4; v.instr = instr;
        v.rd1 = 32'h1111_0000 ^ pc4; v.rd2 = 32'h2222_0000 ^ pc4; v.imm = 32'hFFFF_0000 | pc4;
        v.rs = rs; v.rt = rt; v.rd = rd; v.ctrl = ctrl;
        v.exp_lus = exp_lus; v.exp_valid = exp_valid;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        mem_hold = v.hold; id_shouldStall = v.stall;
        id_pc_4 = v.pc4; id_instruction = v.instr; id_regData1 = v.rd1;
        id_regData2 = v.rd2; id_immediate = v.imm;
        id_rs = v.rs; id_rt = v.rt; id_rd = v.rd; id_ctrl = v.ctrl;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_pc4"}, ex_pc_4, 32'h0);
        chk({tag, "_instr"}, ex_instruction, 32'h0);
        chk({tag, "_rd1"}, ex_regData1, 32'h0);
        chk({tag, "_rd2"}, ex_regData2, 32'h0);
        chk({tag, "_imm"}, ex_immediate, 32'h0);
        chk({tag, "_rsrtrd"}, {17'h0, ex_rs, ex_rt, ex_rd}, 32'h0);
        chk({tag, "_ctrl"}, {20'h0, ex_ctrl}, 32'h0);
        chk({tag, "_valid"}, {31'h0, ex_valid}, 32'h0);
        chk({tag, "_lus"}, {31'h0, loadUseStall}, 32'h0);
    endtask

    task automatic check_sb(input int idx);
        out_t e;
        string t;
        t = $sformatf("v%0d", idx);
        tests++;
        if (sbq.size() == 0) begin
            fails++;
            $display("FAIL %s_sb: got empty queue, expected an entry", t);
        end else begin
            e = sbq.pop_front();
            chk({t, "_pc4"}, ex_pc_4, e.pc4);
            chk({t, "_instr"}, ex_instruction, e.instr);
            chk({t, "_rd1"}, ex_regData1, e.rd1);
            chk({t, "_rd2"}, ex_regData2, e.rd2);
            chk({t, "_imm"}, ex_immediate, e.imm);
            chk({t, "_rsrtrd"}, {17'h0, ex_rs, ex_rt, ex_rd}, {17'h0, e.rs, e.rt, e.rd});
            chk({t, "_ctrl"}, {20'h0, ex_ctrl}, {20'h0, e.ctrl});
            chk({t, "_valid"}, {31'h0, ex_valid}, {31'h0, e.valid});
        end
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        logic hz;
        @(negedge clk);
        drive(v);
        #1;
        chk($sformatf("v%0d_lus", idx), {31'h0, loadUseStall}, {31'h0, v.exp_lus});
        hz = model.valid && model.ctrl[1] && (model.rd != 5'd0)
             && ((model.rd == v.rs) || (model.rd == v.rt));
        if (!v.hold) begin
            if (hz || v.stall) begin
                model = '0;
            end else begin
                model.pc4 = v.pc4; model.instr = v.instr; model.rd1 = v.rd1;
                model.rd2 = v.rd2; model.imm = v.imm; model.rs = v.rs;
                model.rt = v.rt; model.rd = v.rd; model.ctrl = v.ctrl;
                model.valid = 1'b1;
            end
        end
        sbq.push_back(model);
        @(posedge clk);
        #1;
        check_sb(idx);
        chk($sformatf("v%0d_valid_tbl", idx), {31'h0, ex_valid}, {31'h0, v.exp_valid});
    endtask

    initial begin
        vec_t idle, v;
        idle = mk(0, 0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 12'h0, 0, 0);
        //           hold stall pc4         instr         rs  rt  rd  ctrl    lus valid
        vecs[0]  = mk(0, 0, 32'h0000_0008, 32'h0022_1820, 1,  2,  3,  12'h001, 0, 1); // add $3,$1,$2
        vecs[1]  = mk(0, 0, 32'h0000_000C, 32'h8C25_0000, 1,  5,  5,  12'h003, 0, 1); // lw $5
        vecs[2]  = mk(0, 0, 32'h0000_0010, 32'h00A2_3020, 5,  2,  6,  12'h001, 1, 0); // use $5 -> bubble
        vecs[3]  = mk(0, 0, 32'h0000_0010, 32'h00A2_3020, 5,  2,  6,  12'h001, 0, 1); // reissue
        vecs[4]  = mk(0, 0, 32'h0000_0014, 32'h8C20_0000, 1,  0,  0,  12'h003, 0, 1); // lw $0
        vecs[5]  = mk(0, 0, 32'h0000_0018, 32'h0000_1020, 0,  0,  2,  12'h001, 0, 1); // no stall on $0
        vecs[6]  = mk(0, 0, 32'h0000_001C, 32'h8C27_0004, 1,  7,  7,  12'h003, 0, 1); // lw $7
        vecs[7]  = mk(1, 0, 32'h0000_0020, 32'h0047_4020, 2,  7,  8,  12'h001, 1, 1); // hold + hazard
        vecs[8]  = mk(1, 0, 32'h0000_0020, 32'h0047_4020, 2,  7,  8,  12'h001, 1, 1);
        vecs[9]  = mk(1, 0, 32'h0000_0020, 32'h0047_4020, 2,  7,  8,  12'h001, 1, 1);
        vecs[10] = mk(0, 0, 32'h0000_0020, 32'h0047_4020, 2,  7,  8,  12'h001, 1, 0); // bubble lands
        vecs[11] = mk(0, 0, 32'h0000_0020, 32'h0047_4020, 2,  7,  8,  12'h001, 0, 1);
        vecs[12] = mk(0, 1, 32'h0000_0040, 32'h0109_5020, 8,  9,  10, 12'h001, 0, 0); // external stall
        vecs[13] = mk(0, 0, 32'h0000_0040, 32'h0109_5020, 8,  9,  10, 12'h001, 0, 1);
        vecs[14] = mk(1, 0, 32'h0000_0044, 32'hDEAD_BEEF, 1,  1,  1,  12'hFFF, 0, 1); // hold, keep
        vecs[15] = mk(0, 1, 32'h0000_0048, 32'h0000_0000, 0,  0,  0,  12'h000, 0, 0);
        vecs[16] = mk(1, 0, 32'h0000_004C, 32'h1234_5678, 3,  4,  5,  12'h7FF, 0, 0); // hold bubble
        vecs[17] = mk(0, 0, 32'h0000_0050, 32'hA5A5_5A5A, 31, 30, 29, 12'hABC, 0, 1);

        // Reset and async reset in the middle of a stall.
        rst = 1'b1;
        drive(idle);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_zero("reset");
        @(negedge clk);
        drive(vecs[1]);
        @(posedge clk);
        #1;
        chk("pre_rst_valid", {31'h0, ex_valid}, 32'h1);
        @(negedge clk);
        drive(vecs[2]);
        #1;
        chk("pre_rst_lus", {31'h0, loadUseStall}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        drive(vecs[0]);
        @(posedge clk);
        #1;
        chk("post_rst_valid", {31'h0, ex_valid}, 32'h1);
        chk("post_rst_pc4", ex_pc_4, 32'h0000_0008);
        chk("post_rst_instr", ex_instruction, 32'h0022_1820);

        // Table-driven main sequence from a clean reset.
        @(negedge clk);
        rst = 1'b1;
        drive(idle);
        #1;
        rst = 1'b0;
        model = '0;
        for (int i = 0; i < 18; i++) begin
            v = vecs[i];
            apply_vec(i, v);
        end

`ifdef ID_EX_BUBBLE_COUNT_EN
        @(negedge clk);
        rst = 1'b1;
        drive(idle);
        #1;
        chk("cnt_reset", bubble_count, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            id_shouldStall = 1'b1;
            mem_hold = (i >= 2);
            @(posedge clk);
        end
        #1;
        chk("cnt_hold_mix", bubble_count, 32'h2);
        @(negedge clk);
        force dut.bubble_count = 32'hFFFF_FFFF;
        #1;
        release dut.bubble_count;
        id_shouldStall = 1'b1;
        mem_hold = 1'b0;
        @(posedge clk);
        #1;
        chk("cnt_wrap", bubble_count, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
